wb_regfile: RTL

//  Writeback stage directly downstream of the memory stage. Registers the MEM/WB

---
 rtl/wb_regfile_if.sv | 38 +++
 rtl/wb_regfile.sv | 85 ++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// Bundle of MEM/WB result, hazard controls, decode read ports and staged result.
// Latency: none (wires only).
// Backpressure: none on the bus; stall/flush come from hazard control, no ready back to MEM.
interface wb_regfile_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] dest_reg_value_memwb_p1;
    logic [IDX_W-1:0]  dest_reg_index_memwb_p1;
    logic              dest_reg_write_valid_memwb_p1;
    logic              stall_memwb;
    logic              flush_memwb;
    logic [IDX_W-1:0]  rd_index_a_idrf_p0;
    logic [IDX_W-1:0]  rd_index_b_idrf_p0;
    logic [DATA_W-1:0] rd_data_a_idrf_p0;
    logic [DATA_W-1:0] rd_data_b_idrf_p0;
    logic              wb_valid_wb_p2;
    logic [IDX_W-1:0]  wb_index_wb_p2;
    logic [DATA_W-1:0] wb_value_wb_p2;
    logic [CNT_W-1:0]  retire_count;

    // Pipeline side: drives results, controls and read indices; observes the rest.
    modport master (
        output dest_reg_value_memwb_p1, dest_reg_index_memwb_p1, dest_reg_write_valid_memwb_p1,
        output stall_memwb, flush_memwb, rd_index_a_idrf_p0, rd_index_b_idrf_p0,
        input  rd_data_a_idrf_p0, rd_data_b_idrf_p0,
        input  wb_valid_wb_p2, wb_index_wb_p2, wb_value_wb_p2, retire_count
    );

    // Register file side.
    modport slave (
        input  dest_reg_value_memwb_p1, dest_reg_index_memwb_p1, dest_reg_write_valid_memwb_p1,
        input  stall_memwb, flush_memwb, rd_index_a_idrf_p0, rd_index_b_idrf_p0,
        output rd_data_a_idrf_p0, rd_data_b_idrf_p0,
        output wb_valid_wb_p2, wb_index_wb_p2, wb_value_wb_p2, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage register plus 8x16 architectural register file with two async read ports.
// Latency: result staged at edge N, committed to the array at edge N+1; reads combinational.
// Backpressure: stall holds (and recommits) the staged entry, flush kills it; none toward MEM.
// Optional: define WB_BYPASS_EN to let reads see the staged result one cycle before commit.
module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 3,
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    logic              wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0]  wb_index_q, wb_index_d;
    logic [DATA_W-1:0] wb_value_q, wb_value_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Stage register next state and retire count: flush beats stall beats load.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_index_d   = wb_index_q;
        wb_value_d   = wb_value_q;
        retire_cnt_d = retire_cnt_q;
        if (bus.flush_memwb) begin
            wb_valid_d = 1'b0;
        end else if (!bus.stall_memwb) begin
            wb_valid_d = bus.dest_reg_write_valid_memwb_p1;
            wb_index_d = bus.dest_reg_index_memwb_p1;
            wb_value_d = bus.dest_reg_value_memwb_p1;
            if (bus.dest_reg_write_valid_memwb_p1) begin
                retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Commit whatever was staged before this edge; stalls simply rewrite the same value.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid_q) begin
            regs_d[wb_index_q] = wb_value_q;
        end
    end

    // State update; synchronous reset drops any uncommitted staged write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_index_q   <= '0;
            wb_value_q   <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_index_q   <= wb_index_d;
            wb_value_q   <= wb_value_d;
            retire_cnt_q <= retire_cnt_d;
            regs_q       <= regs_d;
        end
    end

    // Decode read ports; without bypass a same-edge commit is invisible until after the edge.
    always_comb begin
`ifdef WB_BYPASS_EN
        bus.rd_data_a_idrf_p0 = (wb_valid_q && (wb_index_q == bus.rd_index_a_idrf_p0)) ?
                                wb_value_q : regs_q[bus.rd_index_a_idrf_p0];
        bus.rd_data_b_idrf_p0 = (wb_valid_q && (wb_index_q == bus.rd_index_b_idrf_p0)) ?
                                wb_value_q : regs_q[bus.rd_index_b_idrf_p0];
`else
        bus.rd_data_a_idrf_p0 = regs_q[bus.rd_index_a_idrf_p0];
        bus.rd_data_b_idrf_p0 = regs_q[bus.rd_index_b_idrf_p0];
`endif
    end

    // Staged entry is exported as the forwarding source.
    assign bus.wb_valid_wb_p2 = wb_valid_q;
    assign bus.wb_index_wb_p2 = wb_index_q;
    assign bus.wb_value_wb_p2 = wb_value_q;
    assign bus.retire_count   = retire_cnt_q;
endmodule
